// File: rtl/control_sequencer.sv
// control_sequencer: captures an instruction word and steps it through
// timesteps T0..T3, driving bus select, load enables, ALU op and status.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   run           start request (sampled in T0)
//   din           instruction word / immediate
//   sel           bus mux select (0..7 reg, 8 din, 10 G)
//   r_in          one-hot register-file load enable
//   a_in, g_in    ALU operand / result register load enables
//   alu_op        00 add, 01 sub, 10 and
//   ir_in         IR capture strobe
//   done          instruction complete pulse
//   illegal       undefined-opcode retire pulse
//   busy          high in T1..T3
module control_sequencer #(
  parameter int         DATA_W  = 16,
  parameter logic [3:0] SEL_DIN = 4'd8,
  parameter logic [3:0] SEL_G   = 4'd10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic [3:0]        sel,
  output logic [7:0]        r_in,
  output logic              a_in,
  output logic              g_in,
  output logic [1:0]        alu_op,
  output logic              ir_in,
  output logic              done,
  output logic              illegal,
  output logic              busy
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  step_e             step_q, step_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [3:0] opc;
  logic [2:0] rx, ry;
  logic       is_mv, is_mvi, is_alu, is_bad;
  logic [1:0] op_d;

  logic [3:0] sel_d;
  logic [7:0] r_in_d;
  logic       a_in_d, g_in_d, ir_in_d;
  logic       done_d, ill_d, busy_d;

  logic unused_ir;

  assign opc = ir_q[15:12];
  assign rx  = ir_q[11:9];
  assign ry  = ir_q[8:6];
  assign unused_ir = ^ir_q[5:0];

  always_comb begin
    is_mv  = 1'b0;
    is_mvi = 1'b0;
    is_alu = 1'b0;
    is_bad = 1'b0;
    op_d   = 2'b00;
    unique case (1'b1)
      (opc == 4'd0): is_mv = 1'b1;
      (opc == 4'd1): is_mvi = 1'b1;
      (opc == 4'd2): is_alu = 1'b1;
      (opc == 4'd3): begin
        is_alu = 1'b1;
        op_d   = 2'b01;
      end
      (opc == 4'd4): begin
        is_alu = 1'b1;
        op_d   = 2'b10;
      end
      default: is_bad = 1'b1;
    endcase
  end

  always_comb begin
    step_d  = step_q;
    ir_d    = ir_q;
    sel_d   = 4'd0;
    r_in_d  = 8'd0;
    a_in_d  = 1'b0;
    g_in_d  = 1'b0;
    ir_in_d = 1'b0;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    busy_d  = (step_q != T0);
    unique case (step_q)
      T0: begin
        ir_in_d = run;
        if (run) begin
          ir_d   = din;
          step_d = T1;
        end
      end
      T1: begin
        step_d = T0;
        unique case (1'b1)
          is_mv: begin
            sel_d  = {1'b0, ry};
            r_in_d = 8'd1 << rx;
            done_d = 1'b1;
          end
          is_mvi: begin
            sel_d  = SEL_DIN;
            r_in_d = 8'd1 << rx;
            done_d = 1'b1;
          end
          is_alu: begin
            sel_d  = {1'b0, rx};
            a_in_d = 1'b1;
            step_d = T2;
          end
          default: begin
            done_d = 1'b1;
            ill_d  = is_bad;
          end
        endcase
      end
      T2: begin
        step_d = T0;
        if (is_alu) begin
          sel_d  = {1'b0, ry};
          g_in_d = 1'b1;
          step_d = T3;
        end
      end
      default: begin
        step_d = T0;
        if (is_alu) begin
          sel_d  = SEL_G;
          r_in_d = 8'd1 << rx;
          done_d = 1'b1;
        end
      end
    endcase
  end

  // Outputs are forced low while reset is held, independent of run.
  always_comb begin
    sel     = rst_n ? sel_d : 4'd0;
    r_in    = rst_n ? r_in_d : 8'd0;
    a_in    = rst_n & a_in_d;
    g_in    = rst_n & g_in_d;
    alu_op  = (rst_n & g_in_d) ? op_d : 2'b00;
    ir_in   = rst_n & ir_in_d;
    done    = rst_n & done_d;
    illegal = rst_n & ill_d;
    busy    = rst_n & busy_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

endmodule
